ft2232_bus_scheduler: RTL and testbench

FT2232_BUS_SCHEDULER -- requirements
Module: ft2232_bus_scheduler

---
 rtl/ft2232_bus_scheduler.sv | 179 +++++++++++++++++
 tb/tb_ft2232_bus_scheduler.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft2232_bus_scheduler.sv
// FT2232 synchronous-FIFO bus scheduler: two TX sources and one RX sink share one half-duplex bus.
// Optional macro FT_SCHED_RR_EN selects a round-robin TX grant; without it source 0 wins ties.
module ft2232_bus_scheduler #(
  parameter int unsigned MAX_BURST = 64
) (
  input  logic       fifo_clk_i,
  input  logic       reset_n_i,
  input  logic       fifo_txe_n_i,
  input  logic       fifo_rxf_n_i,
  input  logic [7:0] fifo_data_i,
  output logic [7:0] fifo_data_o,
  output logic       fifo_data_oe_o,
  output logic       fifo_oe_n_o,
  output logic       fifo_rd_n_o,
  output logic       fifo_wr_n_o,
  input  logic [7:0] tx0_data_i,
  input  logic       tx0_valid_i,
  output logic       tx0_ready_o,
  input  logic [7:0] tx1_data_i,
  input  logic       tx1_valid_i,
  output logic       tx1_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_afull_i,
  output logic       busy_o
);

  // state     | meaning
  // S_IDLE    | bus parked (oe_n high, not driven), arbitrating
  // S_WR      | write burst from the latched source, FPGA drives the bus
  // S_RD_TA   | oe_n low, bus turnaround before the first rd_n
  // S_RD      | read burst, one byte per cycle while rd_n and rxf_n are low
  // S_RD_EXIT | rd_n high, oe_n released on the next edge
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_TA, S_RD, S_RD_EXIT} state_t;

  localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
  localparam logic [7:0] MAX_M1 = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic       oe_n_q, oe_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       data_oe_q, data_oe_d;
  logic [7:0] data_q, data_d;
  logic [7:0] cnt_q, cnt_d;
  logic       grant_q, grant_d;
  logic       rd_pref_q, rd_pref_d;

  logic       wr_ok, rd_ok, grant_sel, src_valid, accept, rx_fire;
  logic [7:0] src_data;

`ifdef FT_SCHED_RR_EN
  logic       last_grant_q, last_grant_d;
`endif

  assign wr_ok     = (tx0_valid_i | tx1_valid_i) & ~fifo_txe_n_i;
  assign rd_ok     = ~fifo_rxf_n_i & ~rx_afull_i;
  assign src_valid = grant_q ? tx1_valid_i : tx0_valid_i;
  assign src_data  = grant_q ? tx1_data_i : tx0_data_i;
  assign accept    = (state_q == S_WR) & src_valid & ~fifo_txe_n_i & (cnt_q < MAX_B);
  assign rx_fire   = (state_q == S_RD) & ~rd_n_q & ~fifo_rxf_n_i;

`ifdef FT_SCHED_RR_EN
  // On a tie the source granted last time yields.
  assign grant_sel = (tx0_valid_i & tx1_valid_i) ? ~last_grant_q : ~tx0_valid_i;
`else
  assign grant_sel = ~tx0_valid_i;
`endif

  assign tx0_ready_o    = accept & ~grant_q;
  assign tx1_ready_o    = accept & grant_q;
  assign rx_valid_o     = rx_fire;
  assign rx_data_o      = fifo_data_i;
  assign fifo_data_o    = data_q;
  assign fifo_data_oe_o = data_oe_q;
  assign fifo_oe_n_o    = oe_n_q;
  assign fifo_rd_n_o    = rd_n_q;
  assign fifo_wr_n_o    = wr_n_q;
  assign busy_o         = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    oe_n_d    = oe_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = 1'b1;
    data_oe_d = data_oe_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    rd_pref_d = rd_pref_q;
`ifdef FT_SCHED_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A read owed after a write burst takes precedence over new TX traffic.
        if (rd_ok && (rd_pref_q || !wr_ok)) begin
          state_d   = S_RD_TA;
          oe_n_d    = 1'b0;
          rd_pref_d = 1'b0;
        end else if (wr_ok) begin
          state_d   = S_WR;
          data_oe_d = 1'b1;
          grant_d   = grant_sel;
          cnt_d     = 8'd0;
`ifdef FT_SCHED_RR_EN
          last_grant_d = grant_sel;
`endif
        end
      end
      S_WR: begin
        if (accept) begin
          wr_n_d = 1'b0;
          data_d = src_data;
          cnt_d  = cnt_q + 8'd1;
        end else begin
          state_d   = S_IDLE;
          data_oe_d = 1'b0;
          rd_pref_d = rd_ok;
        end
      end
      S_RD_TA: begin
        state_d = S_RD;
        rd_n_d  = 1'b0;
        cnt_d   = 8'd0;
      end
      S_RD: begin
        if (rx_fire) cnt_d = cnt_q + 8'd1;
        if (fifo_rxf_n_i || rx_afull_i || (rx_fire && cnt_q == MAX_M1)) begin
          state_d = S_RD_EXIT;
          rd_n_d  = 1'b1;
        end
      end
      S_RD_EXIT: begin
        state_d = S_IDLE;
        oe_n_d  = 1'b1;
      end
      default: begin
        state_d   = S_IDLE;
        oe_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      oe_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      data_q    <= 8'd0;
      cnt_q     <= 8'd0;
      grant_q   <= 1'b0;
      rd_pref_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      oe_n_q    <= oe_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      data_oe_q <= data_oe_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      rd_pref_q <= rd_pref_d;
    end
  end

`ifdef FT_SCHED_RR_EN
  // Reset value makes source 0 win the first tie.
  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) last_grant_q <= 1'b1;
    else            last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: tb/tb_ft2232_bus_scheduler.sv
// Bench for ft2232_bus_scheduler: FT2232 device and TX source models, burst-level scheduling reference.
module tb_ft2232_bus_scheduler;
  localparam int MAX_B = 4;
`ifdef FT_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       txe_n = 1'b0;
  logic       rxf_n = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe, oe_n, rd_n, wr_n;
  logic [7:0] tx0_d = 8'h00, tx1_d = 8'h00;
  logic       tx0_v = 1'b0, tx1_v = 1'b0;
  logic       tx0_r, tx1_r;
  logic [7:0] rx_d;
  logic       rx_v;
  logic       afull = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  ft2232_bus_scheduler #(.MAX_BURST(MAX_B)) dut (
    .fifo_clk_i(clk), .reset_n_i(rst_n),
    .fifo_txe_n_i(txe_n), .fifo_rxf_n_i(rxf_n),
    .fifo_data_i(d_in), .fifo_data_o(d_out), .fifo_data_oe_o(d_oe),
    .fifo_oe_n_o(oe_n), .fifo_rd_n_o(rd_n), .fifo_wr_n_o(wr_n),
    .tx0_data_i(tx0_d), .tx0_valid_i(tx0_v), .tx0_ready_o(tx0_r),
    .tx1_data_i(tx1_d), .tx1_valid_i(tx1_v), .tx1_ready_o(tx1_r),
    .rx_data_o(rx_d), .rx_valid_o(rx_v), .rx_afull_i(afull), .busy_o(busy)
  );

  logic [7:0] src0_q[$], src1_q[$], host_q[$];
  logic [7:0] wr_log[$], rx_log[$];
  int         burst_log[$], exp_bursts[$];
  int         oe_fall[$], oe_rise[$], rd_fall[$], rd_rise[$];
  int         viol = 0, cyc = 0, wrun = 0, rrun = 0;
  logic       wsrc = 1'b0, prev_oe_n = 1'b1, prev_rd_n = 1'b1;
  logic       m_wf, m_rf, m_a0, m_a1;
  int         checks = 0, failures = 0;

  function automatic int bw(input int src, input int len);
    return (1 << 16) | (src << 8) | len;
  endfunction

  function automatic int br(input int len);
    return len;
  endfunction

  function automatic bit q8_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit qi_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Device/source model: sample pre-edge bus state, then update the driven side 1 time unit later.
  always @(posedge clk) begin
    cyc++;
    m_wf = !wr_n && !txe_n;
    m_rf = !rd_n && !rxf_n;
    m_a0 = tx0_v && tx0_r;
    m_a1 = tx1_v && tx1_r;
    if (d_oe && !oe_n) viol++;
    if (!wr_n && !d_oe) viol++;
    if (!rd_n && oe_n) viol++;
    if (rx_v !== m_rf) viol++;
    if (tx0_r && tx1_r) viol++;
    if (m_wf) begin
      if (wrun == 0) wsrc = d_out[7];
      wrun++;
      wr_log.push_back(d_out);
    end else if (wrun > 0) begin
      burst_log.push_back(bw(int'(wsrc), wrun));
      wrun = 0;
    end
    if (rx_v) rx_log.push_back(rx_d);
    if (m_rf) rrun++;
    else if (rrun > 0) begin
      burst_log.push_back(br(rrun));
      rrun = 0;
    end
    if (prev_oe_n && !oe_n) oe_fall.push_back(cyc);
    if (!prev_oe_n && oe_n) oe_rise.push_back(cyc);
    if (prev_rd_n && !rd_n) rd_fall.push_back(cyc);
    if (!prev_rd_n && rd_n) rd_rise.push_back(cyc);
    prev_oe_n = oe_n;
    prev_rd_n = rd_n;
    #1;
    if (m_a0) void'(src0_q.pop_front());
    if (m_a1) void'(src1_q.pop_front());
    if (m_rf) void'(host_q.pop_front());
    tx0_v = (src0_q.size() != 0);
    tx0_d = (src0_q.size() != 0) ? src0_q[0] : 8'h00;
    tx1_v = (src1_q.size() != 0);
    tx1_d = (src1_q.size() != 0) ? src1_q[0] : 8'h00;
    rxf_n = (host_q.size() == 0);
    d_in  = (host_q.size() != 0) ? host_q[0] : 8'h00;
  end

  task automatic clear_logs();
    wr_log.delete(); rx_log.delete(); burst_log.delete();
    oe_fall.delete(); oe_rise.delete(); rd_fall.delete(); rd_rise.delete();
    viol = 0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (src0_q.size() == 0 && src1_q.size() == 0 && host_q.size() == 0 &&
          !busy && wr_n && wrun == 0 && rrun == 0) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic split_wr(output logic [7:0] q0[$], output logic [7:0] q1[$]);
    q0.delete(); q1.delete();
    foreach (wr_log[i]) begin
      if (wr_log[i][7]) q1.push_back(wr_log[i]);
      else q0.push_back(wr_log[i]);
    end
  endtask

  // Transaction-level schedule: a write burst is followed by a read when one is pending,
  // otherwise writes win; each burst takes at most MAX_B bytes from one stream.
  task automatic build_model(input int n0_in, input int n1_in, input int nr_in);
    int n0 = n0_in, n1 = n1_in, nr = nr_in, last_src = 1, len, src;
    bit last_wr = 1'b0;
    exp_bursts.delete();
    while (n0 + n1 + nr > 0) begin
      if ((last_wr && nr > 0) || (n0 + n1 == 0)) begin
        len = (nr < MAX_B) ? nr : MAX_B;
        exp_bursts.push_back(br(len));
        nr -= len;
        last_wr = 1'b0;
      end else begin
        if (RR && n0 > 0 && n1 > 0) src = (last_src == 0) ? 1 : 0;
        else src = (n0 > 0) ? 0 : 1;
        if (src == 0) begin len = (n0 < MAX_B) ? n0 : MAX_B; n0 -= len; end
        else begin len = (n1 < MAX_B) ? n1 : MAX_B; n1 -= len; end
        exp_bursts.push_back(bw(src, len));
        last_src = src;
        last_wr = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int exp_b[$];
    src0_q.push_back(8'h05); src1_q.push_back(8'h85); host_q.push_back(8'h5A);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({oe_n, rd_n, wr_n, d_oe, rx_v, tx0_r, tx1_r, busy} !== 8'b1110_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 11100000", {oe_n, rd_n, wr_n, d_oe, rx_v, tx0_r, tx1_r, busy});
    end
    checks++;
    if (d_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h required 00", d_out);
    end
    @(negedge clk) rst_n = 1'b1;
    wait_drain(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_drain: idle=%0b required 1", ok); end
    exp_b = '{bw(0, 1), br(1), bw(1, 1)};
    checks++;
    if (!qi_eq(burst_log, exp_b)) begin
      failures++;
      $display("FAIL reset_first_sched: got %p required %p", burst_log, exp_b);
    end
    clear_logs();
  endtask

  task automatic test_write_burst();
    bit ok;
    logic [7:0] exp_w[$];
    int exp_b[$];
    clear_logs();
    exp_w = '{8'h11, 8'h22, 8'h33};
    exp_b = '{bw(0, 3)};
    @(negedge clk);
    foreach (exp_w[i]) src0_q.push_back(exp_w[i]);
    wait_drain(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr_drain: idle=%0b required 1", ok); end
    checks++;
    if (!q8_eq(wr_log, exp_w)) begin
      failures++;
      $display("FAIL wr_data: got %p required %p", wr_log, exp_w);
    end
    checks++;
    if (!qi_eq(burst_log, exp_b)) begin
      failures++;
      $display("FAIL wr_consecutive: got %p required %p", burst_log, exp_b);
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL wr_protocol: violations=%0d required 0", viol); end
  endtask

  task automatic test_read_burst();
    bit ok;
    logic [7:0] exp_r[$];
    int exp_b[$];
    clear_logs();
    exp_r = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_b = '{br(4), br(1)};
    @(negedge clk);
    foreach (exp_r[i]) host_q.push_back(exp_r[i]);
    wait_drain(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_drain: idle=%0b required 1", ok); end
    checks++;
    if (!q8_eq(rx_log, exp_r)) begin
      failures++;
      $display("FAIL rd_data: got %p required %p", rx_log, exp_r);
    end
    checks++;
    if (!qi_eq(burst_log, exp_b)) begin
      failures++;
      $display("FAIL rd_bursts: got %p required %p", burst_log, exp_b);
    end
    checks++;
    if (oe_fall.size() != 2 || rd_fall.size() != 2 || rd_rise.size() != 2 || oe_rise.size() != 2) begin
      failures++;
      $display("FAIL rd_strobe_count: got %0d/%0d/%0d/%0d required 2/2/2/2",
               oe_fall.size(), rd_fall.size(), rd_rise.size(), oe_rise.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_fall[i] - oe_fall[i] != 1) begin
          failures++;
          $display("FAIL rd_turnaround%0d: oe_n->rd_n gap=%0d required 1", i, rd_fall[i] - oe_fall[i]);
        end
        checks++;
        if (oe_rise[i] - rd_rise[i] != 1) begin
          failures++;
          $display("FAIL rd_exit%0d: rd_n->oe_n gap=%0d required 1", i, oe_rise[i] - rd_rise[i]);
        end
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL rd_protocol: violations=%0d required 0", viol); end
  endtask

  task automatic test_alternation();
    bit ok;
    logic [7:0] exp_w[$], exp_r[$], got0[$], got1[$];
    int exp_b[$];
    clear_logs();
    for (int i = 0; i < 12; i++) exp_w.push_back({1'b1, 7'($urandom)});
    for (int i = 0; i < 6; i++) exp_r.push_back(8'($urandom));
    exp_b = '{bw(1, 4), br(4), bw(1, 4), br(2), bw(1, 4)};
    @(negedge clk);
    foreach (exp_w[i]) src1_q.push_back(exp_w[i]);
    foreach (exp_r[i]) host_q.push_back(exp_r[i]);
    wait_drain(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL alt_drain: idle=%0b required 1", ok); end
    checks++;
    if (!qi_eq(burst_log, exp_b)) begin
      failures++;
      $display("FAIL alt_sched: got %p required %p", burst_log, exp_b);
    end
    split_wr(got0, got1);
    checks++;
    if (!q8_eq(got1, exp_w)) begin
      failures++;
      $display("FAIL alt_wdata: got %p required %p", got1, exp_w);
    end
    checks++;
    if (!q8_eq(rx_log, exp_r)) begin
      failures++;
      $display("FAIL alt_rdata: got %p required %p", rx_log, exp_r);
    end
  endtask

  task automatic test_afull();
    bit ok, seen;
    int n_at, extra;
    logic [7:0] exp_r[$];
    clear_logs();
    for (int i = 0; i < 10; i++) exp_r.push_back(8'($urandom));
    @(negedge clk);
    foreach (exp_r[i]) host_q.push_back(exp_r[i]);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rx_v) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL afull_start: rx_valid seen=%0b required 1", seen); end
    if (seen) begin
      n_at = rx_log.size();
      afull = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_n !== 1'b1) begin failures++; $display("FAIL afull_rd_n: got %b required 1", rd_n); end
      repeat (8) @(negedge clk);
      extra = rx_log.size() - n_at - 1;
      checks++;
      if (extra > 2) begin failures++; $display("FAIL afull_extra: pulses=%0d required <=2", extra); end
      checks++;
      if (oe_n !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL afull_hold: oe_n=%b busy=%b required 1/0", oe_n, busy);
      end
    end
    afull = 1'b0;
    wait_drain(300, ok);
    checks++;
    if (!ok || !q8_eq(rx_log, exp_r)) begin
      failures++;
      $display("FAIL afull_data: idle=%0b got %p required %p", ok, rx_log, exp_r);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok, seen;
    int n;
    logic [7:0] exp_w[$];
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 20; i++) src0_q.push_back(8'(i));
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (wr_log.size() >= 2 && !wr_n) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rstw_start: strobe seen=%0b required 1", seen); end
    n = wr_log.size();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_n, rd_n, oe_n, d_oe, tx0_r, tx1_r} !== 6'b111000) begin
      failures++;
      $display("FAIL rstw_abort: got %b required 111000", {wr_n, rd_n, oe_n, d_oe, tx0_r, tx1_r});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_log.size() != n) begin
      failures++;
      $display("FAIL rstw_no_strobe: writes=%0d required %0d", wr_log.size(), n);
    end
    rst_n = 1'b1;
    wait_drain(300, ok);
    // The byte on the bus when reset hit is lost; everything else is written in order.
    for (int i = 0; i < 20; i++) if (i != n) exp_w.push_back(8'(i));
    checks++;
    if (!ok || !q8_eq(wr_log, exp_w)) begin
      failures++;
      $display("FAIL rstw_resume: idle=%0b got %p required %p", ok, wr_log, exp_w);
    end
  endtask

  task automatic test_priority();
    bit ok;
    int exp_b[$];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src0_q.push_back(8'(8'h10 + i));
      src1_q.push_back(8'(8'h90 + i));
    end
    if (RR) exp_b = '{bw(0, 4), bw(1, 4), bw(0, 2), bw(1, 2)};
    else    exp_b = '{bw(0, 4), bw(0, 2), bw(1, 4), bw(1, 2)};
    wait_drain(300, ok);
    checks++;
    if (!ok || !qi_eq(burst_log, exp_b)) begin
      failures++;
      $display("FAIL prio_sched: idle=%0b got %p required %p", ok, burst_log, exp_b);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n0, n1, nr;
    logic [7:0] e0[$], e1[$], er[$], g0[$], g1[$];
    for (int it = 0; it < 6; it++) begin
      do_reset();
      e0.delete(); e1.delete(); er.delete();
      n0 = $urandom_range(0, 9); n1 = $urandom_range(0, 9); nr = $urandom_range(0, 9);
      for (int i = 0; i < n0; i++) e0.push_back({1'b0, 7'($urandom)});
      for (int i = 0; i < n1; i++) e1.push_back({1'b1, 7'($urandom)});
      for (int i = 0; i < nr; i++) er.push_back(8'($urandom));
      foreach (e0[i]) src0_q.push_back(e0[i]);
      foreach (e1[i]) src1_q.push_back(e1[i]);
      foreach (er[i]) host_q.push_back(er[i]);
      build_model(n0, n1, nr);
      wait_drain(1000, ok);
      split_wr(g0, g1);
      checks++;
      if (!ok || !qi_eq(burst_log, exp_bursts)) begin
        failures++;
        $display("FAIL rand%0d_sched: idle=%0b got %p required %p", it, ok, burst_log, exp_bursts);
      end
      checks++;
      if (!q8_eq(g0, e0) || !q8_eq(g1, e1)) begin
        failures++;
        $display("FAIL rand%0d_wdata: got %p / %p required %p / %p", it, g0, g1, e0, e1);
      end
      checks++;
      if (!q8_eq(rx_log, er)) begin
        failures++;
        $display("FAIL rand%0d_rdata: got %p required %p", it, rx_log, er);
      end
      checks++;
      if (viol != 0) begin failures++; $display("FAIL rand%0d_protocol: violations=%0d required 0", it, viol); end
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_alternation();
    test_afull();
    test_reset_mid_write();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
